// File: rtl/swo_byte_arbiter_pkg.sv
// Shared types and source identifiers for the SWO byte arbiter.
package swo_arb_pkg;

    localparam logic SRC_MANCH = 1'b0;
    localparam logic SRC_UART  = 1'b1;

    typedef logic       src_id_t;
    typedef logic [7:0] byte_t;

endpackage

// File: rtl/swo_byte_arbiter_fifo.sv
// Per-source front end: toggle detection, enable flush, byte FIFO and a
// saturating counter of bytes dropped because the FIFO was full.
module toggle_byte_fifo
    import swo_arb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int OVF_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             avail,
    input  byte_t            src_byte,
    input  logic             pop,
    input  logic             clr_ovf,
    output logic             empty,
    output byte_t            head,
    output logic [OVF_W-1:0] ovf_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic          prev_avail;
    logic          armed;
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    byte_t         mem [FIFO_DEPTH];
    logic          full;
    logic          toggle;
    logic          do_push;
    logic          do_drop;
    logic          do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign toggle  = armed && (avail != prev_avail) && enable;
    assign do_push = toggle && !full;
    assign do_drop = toggle && full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    // The first edge after reset only captures the avail level, so a line
    // already high at reset release is not mistaken for a toggle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_avail <= 1'b0;
            armed      <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            prev_avail <= avail;
            armed      <= 1'b1;
            if (!enable) begin
                rd_ptr <= wr_ptr;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + 1'b1;
                if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= src_byte;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_cnt <= '0;
        end else if (clr_ovf) begin
            ovf_cnt <= '0;
        end else if (do_drop && (ovf_cnt != {OVF_W{1'b1}})) begin
            ovf_cnt <= ovf_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/swo_byte_arbiter.sv
// Merges the Manchester and UART SWO byte streams into one registered
// valid/ready byte output with round-robin arbitration between the sources.
module swo_byte_arbiter
    import swo_arb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int OVF_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       enable,
    input  logic             src0_avail,
    input  logic [7:0]       src0_byte,
    input  logic             src1_avail,
    input  logic [7:0]       src1_byte,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [7:0]       out_byte,
    output logic             out_src,
    input  logic             clr_ovf,
    output logic [OVF_W-1:0] ovf0_cnt,
    output logic [OVF_W-1:0] ovf1_cnt,
    output logic             busy
);

    logic    empty0, empty1;
    byte_t   head0, head1;
    logic    pop0, pop1;
    logic    load;
    src_id_t winner;
    src_id_t last_grant;

    toggle_byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .OVF_W(OVF_W)) u_src0 (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable[0]),
        .avail    (src0_avail),
        .src_byte (src0_byte),
        .pop      (pop0),
        .clr_ovf  (clr_ovf),
        .empty    (empty0),
        .head     (head0),
        .ovf_cnt  (ovf0_cnt)
    );

    toggle_byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .OVF_W(OVF_W)) u_src1 (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable[1]),
        .avail    (src1_avail),
        .src_byte (src1_byte),
        .pop      (pop1),
        .clr_ovf  (clr_ovf),
        .empty    (empty1),
        .head     (head1),
        .ovf_cnt  (ovf1_cnt)
    );

    always_comb begin
        winner = SRC_UART;
        if (!empty0 && !empty1) begin
            winner = ~last_grant;
        end else if (!empty0) begin
            winner = SRC_MANCH;
        end
    end

    assign load = (!out_valid || out_ready) && (!empty0 || !empty1);
    assign pop0 = load && (winner == SRC_MANCH);
    assign pop1 = load && (winner == SRC_UART);
    assign busy = !empty0 || !empty1 || out_valid;

    // last_grant resets to the UART source so the Manchester source wins
    // the first contested slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_byte   <= '0;
            out_src    <= SRC_MANCH;
            last_grant <= SRC_UART;
        end else if (load) begin
            out_valid  <= 1'b1;
            out_byte   <= (winner == SRC_UART) ? head1 : head0;
            out_src    <= winner;
            last_grant <= winner;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_swo_byte_arbiter.sv
// Self-checking bench for swo_byte_arbiter: per-cycle vector table plus
// hand-written overflow, enable, saturation and reset sequences.
module tb_swo_byte_arbiter;

    localparam int DEPTH = 4;
    localparam int OW    = 2;

    typedef struct {
        bit         rst_before;
        bit         tog0;
        logic [7:0] b0;
        bit         tog1;
        logic [7:0] b1;
        bit         ready;
        bit         exp_valid;
        logic [7:0] exp_byte;
        bit         exp_src;
        string      name;
    } vec_t;

    logic          clk;
    logic          rst;
    logic [1:0]    enable;
    logic          src0_avail;
    logic [7:0]    src0_byte;
    logic          src1_avail;
    logic [7:0]    src1_byte;
    logic          out_ready;
    logic          out_valid;
    logic [7:0]    out_byte;
    logic          out_src;
    logic          clr_ovf;
    logic [OW-1:0] ovf0_cnt;
    logic [OW-1:0] ovf1_cnt;
    logic          busy;

    int         checks = 0;
    int         passes = 0;
    bit         sb_on  = 0;
    logic [8:0] sb_q [$];
    vec_t       vecs [$];

    swo_byte_arbiter #(.FIFO_DEPTH(DEPTH), .OVF_W(OW)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .src0_avail (src0_avail),
        .src0_byte  (src0_byte),
        .src1_avail (src1_avail),
        .src1_byte  (src1_byte),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_byte   (out_byte),
        .out_src    (out_src),
        .clr_ovf    (clr_ovf),
        .ovf0_cnt   (ovf0_cnt),
        .ovf1_cnt   (ovf1_cnt),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Handshakes are sampled on the falling edge, where the pre-edge
    // valid/ready pair is stable; inputs only change just after rising edges.
    task automatic step();
        logic [8:0] exp;
        @(negedge clk);
        if (sb_on && !rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                $display("[TB] FAIL sb_unexpected: got byte 0x%0h src %0d, expected no output", out_byte, out_src);
            end else begin
                exp = sb_q.pop_front();
                checkOutput("sb_item", 32'({out_src, out_byte}), 32'(exp));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic tog0(input logic [7:0] b);
        src0_byte  = b;
        src0_avail = ~src0_avail;
    endtask

    task automatic tog1(input logic [7:0] b);
        src1_byte  = b;
        src1_avail = ~src1_avail;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        checkOutput(name, 32'(sb_q.size()), 32'd0);
    endtask

    task automatic add_vec(input bit r, input bit t0, input logic [7:0] b0, input bit t1,
                           input logic [7:0] b1, input bit rdy, input bit ev,
                           input logic [7:0] eb, input bit es, input string nm);
        vec_t v;
        v.rst_before = r;  v.tog0 = t0; v.b0 = b0; v.tog1 = t1; v.b1 = b1;
        v.ready = rdy; v.exp_valid = ev; v.exp_byte = eb; v.exp_src = es; v.name = nm;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        if (v.rst_before) do_reset();
        out_ready = v.ready;
        if (v.tog0) tog0(v.b0);
        if (v.tog1) tog1(v.b1);
        step();
    endtask

    initial begin
        rst = 1'b1; enable = 2'b11; out_ready = 1'b0; clr_ovf = 1'b0;
        src0_avail = 1'b0; src0_byte = '0; src1_avail = 1'b0; src1_byte = '0;

        add_vec(1, 1, 8'hA5, 0, 8'h00, 1, 0, 8'h00, 0, "single_c0");
        add_vec(0, 0, 8'h00, 0, 8'h00, 1, 1, 8'hA5, 0, "single_c1");
        add_vec(0, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0, "single_c2");
        add_vec(1, 1, 8'h11, 1, 8'h22, 1, 0, 8'h00, 0, "rr_c0");
        add_vec(0, 1, 8'h33, 1, 8'h44, 1, 1, 8'h11, 0, "rr_c1");
        add_vec(0, 0, 8'h00, 0, 8'h00, 1, 1, 8'h22, 1, "rr_c2");
        add_vec(0, 0, 8'h00, 0, 8'h00, 1, 1, 8'h33, 0, "rr_c3");
        add_vec(0, 0, 8'h00, 0, 8'h00, 1, 1, 8'h44, 1, "rr_c4");
        add_vec(0, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0, "rr_c5");

        @(posedge clk);
        #1;
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_byte",  32'(out_byte),  32'd0);
        checkOutput("rst_src",   32'(out_src),   32'd0);
        checkOutput("rst_ovf0",  32'(ovf0_cnt),  32'd0);
        checkOutput("rst_ovf1",  32'(ovf1_cnt),  32'd0);
        checkOutput("rst_busy",  32'(busy),      32'd0);
        rst = 1'b0;
        step();

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput({vecs[i].name, "_valid"}, 32'(out_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                checkOutput({vecs[i].name, "_byte"}, 32'(out_byte), 32'(vecs[i].exp_byte));
                checkOutput({vecs[i].name, "_src"},  32'(out_src),  32'(vecs[i].exp_src));
            end
        end

        // Overflow on source 1 with the output stalled.
        sb_on = 1'b1;
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tog1(8'h60 + 8'(k));
            if (k < 5) sb_q.push_back({1'b1, 8'h60 + 8'(k)});
            step();
        end
        checkOutput("ovf_cnt1",   32'(ovf1_cnt),  32'd1);
        checkOutput("ovf_cnt0",   32'(ovf0_cnt),  32'd0);
        checkOutput("ovf_valid",  32'(out_valid), 32'd1);
        checkOutput("ovf_head",   32'(out_byte),  32'h60);
        checkOutput("ovf_busy",   32'(busy),      32'd1);
        step();
        checkOutput("ovf_stable", 32'({out_src, out_byte}), 32'h160);
        out_ready = 1'b1;
        drain("ovf_drain", 20);
        checkOutput("ovf_valid_end", 32'(out_valid), 32'd0);
        checkOutput("ovf_busy_end",  32'(busy),      32'd0);

        // Avail held high through reset release, then a disabled source.
        src0_avail = 1'b1;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            step();
            checkOutput("hold_valid", 32'(out_valid), 32'd0);
        end
        checkOutput("hold_busy", 32'(busy), 32'd0);
        enable = 2'b10;
        for (int k = 0; k < 3; k++) begin
            tog0(8'hC0 + 8'(k));
            step();
        end
        step();
        step();
        checkOutput("dis_valid", 32'(out_valid), 32'd0);
        checkOutput("dis_busy",  32'(busy),      32'd0);
        checkOutput("dis_ovf0",  32'(ovf0_cnt),  32'd0);
        enable = 2'b11;

        // Saturation of the 2-bit counter and clear winning over an increment.
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tog0(8'h90 + 8'(k));
            step();
            if (k >= 5) checkOutput("sat_ovf0", 32'(ovf0_cnt), (k - 4 > 3) ? 32'd3 : 32'(k - 4));
        end
        checkOutput("sat_before_clr", 32'(ovf0_cnt), 32'd3);
        clr_ovf = 1'b1;
        tog0(8'h9A);
        step();
        clr_ovf = 1'b0;
        checkOutput("sat_after_clr", 32'(ovf0_cnt), 32'd0);

        // Reset with bytes queued and the output register full.
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tog0(8'h81 + 8'(k));
            step();
        end
        checkOutput("mid_valid_pre", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("mid_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_byte",  32'(out_byte),  32'd0);
        checkOutput("mid_src",   32'(out_src),   32'd0);
        checkOutput("mid_busy",  32'(busy),      32'd0);
        checkOutput("mid_ovf",   32'({ovf0_cnt, ovf1_cnt}), 32'd0);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        step();
        tog0(8'h77);
        sb_q.push_back({1'b0, 8'h77});
        step();
        drain("mid_drain", 10);
        for (int k = 0; k < 4; k++) step();
        checkOutput("mid_idle", 32'(busy), 32'd0);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
